irq_ctrl: RTL

Memory-mapped interrupt controller sitting directly downstream of the millisecond timer peripheral. Consumes the timer's "count reached zero" flag (src_in[0]) plus other peripheral request lines. Latches rising edges as pending bits, masks and prioritises them, and drives a request/acknowledge/end-of-interrupt handshake to the d16 CPU core. Uses the same 16-bit en/wr_en register-bus style as the other peripherals.

---
 rtl/irq_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped interrupt controller with edge-latched pending bits,
// per-source enable mask, fixed lowest-index priority and a CPU
// request/acknowledge/end-of-interrupt handshake.
// Optional build macro IRQ_CTRL_SYNC_EN adds a 2-flop synchroniser on src_in.
module irq_ctrl #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               wr_en,
  input  logic [1:0]         addr,
  input  logic [15:0]        data_in,
  output logic [15:0]        data_out,
  input  logic [NUM_SRC-1:0] src_in,
  output logic               irq_req,
  output logic [3:0]         irq_vector,
  input  logic               irq_ack
);

  localparam int unsigned DW = 16;
  localparam int unsigned VW = 4;

  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

  state_t state, state_nxt;
  logic [VW-1:0]      vec_nxt;
  logic [VW-1:0]      prio_idx;
  logic [NUM_SRC-1:0] src_s, src_prev, pending, mask, active, rise;
  logic [NUM_SRC-1:0] swi_set, w1c_clr, ack_clr, pend_nxt, vec_onehot;
  logic               wr, eoi, vec_active;
  logic               unused_bits;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NUM_SRC-1:0] sync1, sync2;

  // Two-stage synchroniser; resets high so lines high at release do not fire
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= src_in;
      sync2 <= sync1;
    end
  end
  assign src_s = sync2;
`else
  assign src_s = src_in;
`endif

  assign wr          = en & wr_en;
  assign eoi         = wr && (addr == 2'd2);
  assign rise        = src_s & ~src_prev;
  assign swi_set     = (wr && addr == 2'd3) ? data_in[NUM_SRC-1:0] : '0;
  assign w1c_clr     = (wr && addr == 2'd0) ? data_in[NUM_SRC-1:0] : '0;
  assign vec_onehot  = NUM_SRC'(1) << irq_vector;
  assign ack_clr     = (state == REQ && irq_ack) ? vec_onehot : '0;
  assign pend_nxt    = (pending & ~(w1c_clr | ack_clr)) | rise | swi_set;
  assign active      = pending & mask;
  assign vec_active  = |(active & vec_onehot);
  assign unused_bits = ^data_in;

  // Edge-detect history, pending and mask registers; sets beat clears
  always_ff @(posedge clk) begin
    if (rst) begin
      src_prev <= '1;
      pending  <= '0;
      mask     <= '0;
    end else begin
      src_prev <= src_s;
      pending  <= pend_nxt;
      if (wr && addr == 2'd1) mask <= data_in[NUM_SRC-1:0];
    end
  end

  // Lowest set index of active wins
  always_comb begin
    prio_idx = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (active[i]) prio_idx = VW'(i);
    end
  end

  // FSM state and registered request/vector outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      irq_req    <= 1'b0;
      irq_vector <= '0;
    end else begin
      state      <= state_nxt;
      irq_req    <= (state_nxt == REQ);
      irq_vector <= vec_nxt;
    end
  end

  // Next-state: ack beats a same-cycle drop of the requested source
  always_comb begin
    state_nxt = state;
    vec_nxt   = irq_vector;
    case (state)
      IDLE: begin
        if (|active) begin
          state_nxt = REQ;
          vec_nxt   = prio_idx;
        end
      end
      REQ: begin
        if (irq_ack)          state_nxt = SVC;
        else if (!vec_active) state_nxt = IDLE;
      end
      SVC: begin
        if (eoi) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational read mux; reads have no side effects
  always_comb begin
    data_out = '0;
    case (addr)
      2'd0:    data_out = DW'(pending);
      2'd1:    data_out = DW'(mask);
      2'd2:    data_out = {(state == SVC), 11'b0, irq_vector};
      default: data_out = '0;
    endcase
  end

endmodule
